// File: rtl/mux_pkg.sv
// Shared encodings for the N:1 scan multiplexer.
// Mode select values and FSM state codes.
package mux_pkg;

   localparam logic MODE_MANUAL = 1'b0;
   localparam logic MODE_SCAN   = 1'b1;

   typedef enum logic [1:0] {
      ST_MANUAL     = 2'd0,
      ST_SCAN       = 2'd1,
      ST_SCAN_EMPTY = 2'd2
   } state_e;

endpackage

// File: rtl/mux_n_1_scan_if.sv
// Result stream of the scan multiplexer.
// The master drives the word, the consumer drives ready.
interface mux_n_1_scan_if #(
   parameter int DATA_WIDTH = 8,
   parameter int SEL_WIDTH  = 4
);

   logic [DATA_WIDTH-1:0] MUX_Result_Data_Out;
   logic                  MUX_Result_Valid_Out;
   logic                  MUX_Result_Ready_In;
   logic [SEL_WIDTH-1:0]  Channel_Out;
   logic                  Scan_Wrap_Out;

   modport master (
      output MUX_Result_Data_Out,
      output MUX_Result_Valid_Out,
      output Channel_Out,
      output Scan_Wrap_Out,
      input  MUX_Result_Ready_In
   );

   modport slave (
      input  MUX_Result_Data_Out,
      input  MUX_Result_Valid_Out,
      input  Channel_Out,
      input  Scan_Wrap_Out,
      output MUX_Result_Ready_In
   );

endinterface

// File: rtl/mux_rr_next_finder.sv
// Circular search for the first set mask bit at or above start.
// wrapped flags a hit that lies below start (search passed N-1).
module mux_rr_next_finder #(
   parameter int  NUM_CHANNELS = 16,
   localparam int SEL_WIDTH    = $clog2(NUM_CHANNELS)
) (
   input  logic [NUM_CHANNELS-1:0] mask,
   input  logic [SEL_WIDTH-1:0]    start,
   output logic                    found,
   output logic [SEL_WIDTH-1:0]    index,
   output logic                    wrapped
);

   always_comb begin
      logic [SEL_WIDTH-1:0] pos;
      found = 1'b0;
      index = '0;
      pos   = '0;
      // Walk farthest-first so the nearest hit is the one that sticks.
      for (int k = NUM_CHANNELS - 1; k >= 0; k--) begin
         if (int'(start) + k >= NUM_CHANNELS)
            pos = SEL_WIDTH'(int'(start) + k - NUM_CHANNELS);
         else
            pos = SEL_WIDTH'(int'(start) + k);
         if (mask[pos]) begin
            found = 1'b1;
            index = pos;
         end
      end
      wrapped = found & (index < start);
   end

endmodule

// File: rtl/mux_n_1_scan.sv
// Registered N:1 multiplexer: manual channel select or masked
// round-robin scan with per-channel dwell, valid/ready output.
module mux_n_1_scan
   import mux_pkg::*;
#(
   parameter int  NUM_CHANNELS = 16,
   parameter int  DATA_WIDTH   = 8,
   parameter int  DWELL_WIDTH  = 8,
   localparam int SEL_WIDTH    = $clog2(NUM_CHANNELS)
) (
   input  logic                               Clock_In,
   input  logic                               Reset_In,
   input  logic                               Enable_In,
   input  logic                               Mode_In,
   input  logic [NUM_CHANNELS*DATA_WIDTH-1:0] Data_In,
   input  logic [SEL_WIDTH-1:0]               Select_In,
   input  logic [NUM_CHANNELS-1:0]            Channel_Mask_In,
   input  logic [DWELL_WIDTH-1:0]             Dwell_In,
   mux_n_1_scan_if.master                     mux_result
);

   state_e                 state_q, state_d;
   logic [SEL_WIDTH-1:0]   scan_ptr_q, scan_ptr_d;
   logic                   scan_wrap_q, scan_wrap_d;
   logic [DWELL_WIDTH-1:0] dwell_cnt_q, dwell_cnt_d;
   logic [DATA_WIDTH-1:0]  data_q, data_d;
   logic                   valid_q, valid_d;
   logic [SEL_WIDTH-1:0]   chan_q, chan_d;
   logic                   wrap_q, wrap_d;

   logic                   cand_found;
   logic [SEL_WIDTH-1:0]   cand_idx;
   logic                   cand_wrap;
   logic                   have_src;
   logic [DATA_WIDTH-1:0]  src_data;
   logic [SEL_WIDTH-1:0]   src_chan;
   logic                   src_wrap;
   logic                   ready;
   logic                   load;
   logic                   scan_load;
   logic                   entering_scan;

   assign ready = mux_result.MUX_Result_Ready_In;

   mux_rr_next_finder #(
      .NUM_CHANNELS(NUM_CHANNELS)
   ) u_finder (
      .mask   (Channel_Mask_In),
      .start  (scan_ptr_q),
      .found  (cand_found),
      .index  (cand_idx),
      .wrapped(cand_wrap)
   );

   always_ff @(posedge Clock_In) begin
      if (Reset_In) state_q <= ST_MANUAL;
      else          state_q <= state_d;
   end

   always_comb begin
      state_d = state_q;
      if (Mode_In == MODE_MANUAL)
         state_d = ST_MANUAL;
      else if (Channel_Mask_In == '0)
         state_d = ST_SCAN_EMPTY;
      else
         state_d = ST_SCAN;
   end

   always_comb begin
      have_src = 1'b0;
      src_data = '0;
      src_chan = '0;
      src_wrap = 1'b0;
      unique case (state_q)
         ST_MANUAL: begin
            have_src = 1'b1;
            src_chan = Select_In;
            if (int'(Select_In) < NUM_CHANNELS)
               src_data = Data_In[Select_In*DATA_WIDTH +: DATA_WIDTH];
         end
         ST_SCAN: begin
            have_src = cand_found;
            src_data = Data_In[cand_idx*DATA_WIDTH +: DATA_WIDTH];
            src_chan = cand_idx;
            src_wrap = cand_wrap | scan_wrap_q;
         end
         default: ;
      endcase
   end

   assign load          = Enable_In & (~valid_q | ready) & have_src;
   assign scan_load     = load & (state_q == ST_SCAN);
   assign entering_scan = (state_q == ST_MANUAL) & (state_d != ST_MANUAL);

   // scan_wrap_q remembers that the pointer rolled from N-1 to 0,
   // so the next word still reports the start of a new round.
   always_comb begin
      scan_ptr_d  = scan_ptr_q;
      scan_wrap_d = scan_wrap_q;
      dwell_cnt_d = dwell_cnt_q;
      if (entering_scan) begin
         scan_ptr_d  = '0;
         scan_wrap_d = 1'b0;
         dwell_cnt_d = '0;
      end else if (scan_load) begin
         scan_wrap_d = 1'b0;
         if (dwell_cnt_q == Dwell_In) begin
            dwell_cnt_d = '0;
            if (int'(cand_idx) == NUM_CHANNELS - 1) begin
               scan_ptr_d  = '0;
               scan_wrap_d = 1'b1;
            end else begin
               scan_ptr_d = cand_idx + 1'b1;
            end
         end else begin
            dwell_cnt_d = dwell_cnt_q + 1'b1;
            scan_ptr_d  = cand_idx;
         end
      end
   end

   always_comb begin
      data_d  = data_q;
      valid_d = valid_q;
      chan_d  = chan_q;
      wrap_d  = wrap_q;
      if (!Enable_In) begin
         valid_d = 1'b0;
         data_d  = '0;
         wrap_d  = 1'b0;
      end else if (load) begin
         valid_d = 1'b1;
         data_d  = src_data;
         chan_d  = src_chan;
         wrap_d  = src_wrap;
      end else if (valid_q && ready) begin
         valid_d = 1'b0;
      end
   end

   always_ff @(posedge Clock_In) begin
      if (Reset_In) begin
         scan_ptr_q  <= '0;
         scan_wrap_q <= 1'b0;
         dwell_cnt_q <= '0;
         data_q      <= '0;
         valid_q     <= 1'b0;
         chan_q      <= '0;
         wrap_q      <= 1'b0;
      end else begin
         scan_ptr_q  <= scan_ptr_d;
         scan_wrap_q <= scan_wrap_d;
         dwell_cnt_q <= dwell_cnt_d;
         data_q      <= data_d;
         valid_q     <= valid_d;
         chan_q      <= chan_d;
         wrap_q      <= wrap_d;
      end
   end

   assign mux_result.MUX_Result_Data_Out  = data_q;
   assign mux_result.MUX_Result_Valid_Out = valid_q;
   assign mux_result.Channel_Out          = chan_q;
   assign mux_result.Scan_Wrap_Out        = wrap_q;

endmodule
